// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sample loader.
package fft_pkg;

   // Loader FSM states.
   typedef enum logic [2:0] {
      S_FILL   = 3'd0,
      S_ARM    = 3'd1,
      S_STREAM = 3'd2,
      S_WAIT   = 3'd3,
      S_REL    = 3'd4
   } state_t;

   // Mode codes presented to the FFT core.
   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;

endpackage

// File: rtl/sample_bank.sv
// One N-entry sample bank: synchronous write, asynchronous indexed read.
// Contents are deliberately not reset.
module sample_bank #(
   parameter int N          = 16,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [ADDR_WIDTH-1:0]        waddr,
   input  logic signed [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0]        raddr,
   output logic signed [DATA_WIDTH-1:0] rdata
);

   logic signed [DATA_WIDTH-1:0] mem_q [N];

   // Store the incoming sample at the write index.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_sample_loader.sv
// Ping-pong buffers upstream real samples and hands each full bank to the
// downstream FFT core, one sample per cycle, then waits for the core's done
// handshake before counting the frame.
module fft_sample_loader
   import fft_pkg::*;
#(
   parameter int N          = 16,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = $clog2(N)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [DATA_WIDTH-1:0] s_data,
   input  logic                         fft_done,
   output logic                         fft_en,
   output logic [1:0]                   fft_mode,
   output logic signed [DATA_WIDTH-1:0] fft_x_out,
   output logic [7:0]                   frame_cnt,
   output logic                         busy
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

   state_t                       state_q, state_d;
   logic                         wb_q, wb_d;
   logic                         rb_q, rb_d;
   logic [ADDR_WIDTH-1:0]        wr_idx_q, wr_idx_d;
   logic [ADDR_WIDTH-1:0]        rd_idx_q, rd_idx_d;
   logic [ADDR_WIDTH-1:0]        rd_addr;
   logic [1:0]                   full_q, full_d, set_full, clr_full;
   logic signed [DATA_WIDTH-1:0] x_q, x_d, rd_data;
   logic signed [DATA_WIDTH-1:0] bank_rdata [2];
   logic [7:0]                   frame_cnt_q, frame_cnt_d;
   logic                         transfer;

   assign s_ready   = ~full_q[wb_q];
   assign transfer  = s_valid & s_ready;
   assign busy      = (state_q != S_FILL);
   assign fft_x_out = x_q;
   assign frame_cnt = frame_cnt_q;
   // S_ARM always fetches the first sample of the read bank.
   assign rd_addr   = (state_q == S_ARM) ? '0 : rd_idx_q;
   assign rd_data   = bank_rdata[rb_q];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         sample_bank #(
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_bank (
            .clk   (clk),
            .we    (transfer && (wb_q == 1'(gi))),
            .waddr (wr_idx_q),
            .wdata (s_data),
            .raddr (rd_addr),
            .rdata (bank_rdata[gi])
         );
      end
   endgenerate

   // Write side: advance the fill index and flip banks when one completes.
   always_comb begin
      wb_d     = wb_q;
      wr_idx_d = wr_idx_q;
      set_full = 2'b00;
      if (transfer) begin
         wr_idx_d = wr_idx_q + IDX_ONE;
         if (wr_idx_q == LAST_IDX) begin
            set_full[wb_q] = 1'b1;
            wb_d           = ~wb_q;
         end
      end
   end

   // Read side FSM: next state, core controls and the output sample pipeline.
   always_comb begin
      state_d     = state_q;
      rb_d        = rb_q;
      rd_idx_d    = rd_idx_q;
      x_d         = x_q;
      frame_cnt_d = frame_cnt_q;
      clr_full    = 2'b00;
      fft_en      = 1'b0;
      fft_mode    = MODE_IDLE;
      case (state_q)
         S_FILL: begin
            if (full_q[rb_q]) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            fft_en   = 1'b1;
            fft_mode = MODE_RUN;
            x_d      = rd_data;
            rd_idx_d = IDX_ONE;
            state_d  = S_STREAM;
         end
         S_STREAM: begin
            fft_en   = 1'b1;
            fft_mode = MODE_RUN;
            // rd_idx wraps to 0 during the last sample's cycle.
            if (rd_idx_q == '0) begin
               clr_full[rb_q] = 1'b1;
               rb_d           = ~rb_q;
               state_d        = S_WAIT;
            end else begin
               x_d      = rd_data;
               rd_idx_d = rd_idx_q + IDX_ONE;
            end
         end
         S_WAIT: begin
            fft_en   = 1'b1;
            fft_mode = MODE_RUN;
            if (fft_done) begin
               state_d = S_REL;
            end
         end
         S_REL: begin
            if (!fft_done) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               state_d     = S_FILL;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // Set and clear never target the same bank, so both may act on one edge.
   always_comb begin
      full_d = (full_q | set_full) & ~clr_full;
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FILL;
         wb_q        <= 1'b0;
         rb_q        <= 1'b0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         full_q      <= 2'b00;
         x_q         <= '0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         wb_q        <= wb_d;
         rb_q        <= rb_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         full_q      <= full_d;
         x_q         <= x_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: streaming, done handshake,
// backpressure, same-edge bank swap, mid-stream reset and frame counter wrap.
module tb_fft_sample_loader;

   localparam int N  = 16;
   localparam int DW = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 s_valid;
   logic                 s_ready;
   logic signed [DW-1:0] s_data;
   logic                 fft_done;
   logic                 fft_en;
   logic [1:0]           fft_mode;
   logic signed [DW-1:0] fft_x_out;
   logic [7:0]           frame_cnt;
   logic                 busy;

   int n_cmp = 0;
   int n_bad = 0;

   fft_sample_loader #(
      .N          (N),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .fft_done  (fft_done),
      .fft_en    (fft_en),
      .fft_mode  (fft_mode),
      .fft_x_out (fft_x_out),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      fft_done = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Fill one bank, let it stream, then give the done pulse. Ends in S_FILL.
   task automatic run_frame(input int base);
      for (int i = 0; i < N; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(base + i);
         step();
      end
      s_valid = 1'b0;
      repeat (N + 2) step();
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      fft_done = 1'b0;
      step();
      step();
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (fft_en !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", fft_en); end
      n_cmp++; if (fft_mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode got %b want 00", fft_mode); end
      n_cmp++; if (fft_x_out !== 16'sd0) begin n_bad++; $display("FAIL reset_x got %0d want 0", fft_x_out); end
      n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
      rst = 1'b0;
      step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
      $display("test_reset done");
   endtask

   // Frame 1..16 with fft_done held high through fill/arm/stream (ignored there).
   task automatic test_stream();
      logic signed [DW-1:0] exp_x;
      do_reset();
      fft_done = 1'b1;
      for (int i = 0; i < N; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(i + 1);
         n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready i=%0d got %b want 1", i, s_ready); end
         step();
      end
      s_valid = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fill_busy got %b want 0", busy); end
      step();
      n_cmp++; if (busy !== 1'b1 || fft_en !== 1'b1 || fft_mode !== 2'b01) begin
         n_bad++; $display("FAIL arm_ctrl got busy=%b en=%b mode=%b want 1 1 01", busy, fft_en, fft_mode); end
      n_cmp++; if (fft_x_out !== 16'sd0) begin n_bad++; $display("FAIL arm_x got %0d want 0", fft_x_out); end
      for (int k = 0; k < N; k++) begin
         step();
         exp_x = DW'(k + 1);
         n_cmp++; if (fft_x_out !== exp_x) begin n_bad++; $display("FAIL stream_x k=%0d got %0d want %0d", k, fft_x_out, exp_x); end
         n_cmp++; if (fft_en !== 1'b1 || fft_mode !== 2'b01) begin
            n_bad++; $display("FAIL stream_ctrl k=%0d got en=%b mode=%b want 1 01", k, fft_en, fft_mode); end
         if (k == N - 1) fft_done = 1'b0;
      end
      step();
      n_cmp++; if (fft_en !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL wait_ctrl got en=%b busy=%b want 1 1", fft_en, busy); end
      n_cmp++; if (fft_x_out !== 16'sd16) begin n_bad++; $display("FAIL wait_hold_x got %0d want 16", fft_x_out); end
      $display("test_stream done");
   endtask

   // Continues from S_WAIT left by test_stream.
   task automatic test_release();
      for (int c = 0; c < 4; c++) begin
         step();
         n_cmp++; if (fft_en !== 1'b1) begin n_bad++; $display("FAIL wait_en c=%0d got %b want 1", c, fft_en); end
      end
      fft_done = 1'b1;
      step();
      n_cmp++; if (fft_en !== 1'b0 || fft_mode !== 2'b00 || busy !== 1'b1) begin
         n_bad++; $display("FAIL rel_ctrl got en=%b mode=%b busy=%b want 0 00 1", fft_en, fft_mode, busy); end
      n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL rel_frame_cnt got %0d want 0", frame_cnt); end
      step();
      n_cmp++; if (fft_en !== 1'b0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL rel_hold got en=%b busy=%b want 0 1", fft_en, busy); end
      fft_done = 1'b0;
      step();
      n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL rel_frame_inc got %0d want 1", frame_cnt); end
      n_cmp++; if (busy !== 1'b0 || fft_en !== 1'b0) begin
         n_bad++; $display("FAIL back_to_fill got busy=%b en=%b want 0 0", busy, fft_en); end
      n_cmp++; if (fft_x_out !== 16'sd16) begin n_bad++; $display("FAIL fill_hold_x got %0d want 16", fft_x_out); end
      $display("test_release done");
   endtask

   // 48 samples offered back to back while the core never finishes.
   task automatic test_backpressure();
      int   next;
      logic exp_ready;
      logic signed [DW-1:0] exp_x;
      do_reset();
      next = 1;
      for (int c = 1; c <= 56; c++) begin
         exp_ready = (c <= 32) || (c >= 35 && c <= 50);
         s_valid = 1'b1;
         s_data  = (next <= 48) ? DW'(next) : DW'(999);
         n_cmp++; if (s_ready !== exp_ready) begin
            n_bad++; $display("FAIL bp_ready c=%0d got %b want %b", c, s_ready, exp_ready); end
         step();
         if (exp_ready) next++;
      end
      s_valid = 1'b0;
      // Release frame 1, then frame 2 (bank 1) must stream 17..32.
      fft_done = 1'b1; step(); fft_done = 1'b0; step();
      n_cmp++; if (frame_cnt !== 8'd1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL bp_rel got frame_cnt=%0d busy=%b want 1 0", frame_cnt, busy); end
      step();
      for (int k = 0; k < N; k++) begin
         step();
         exp_x = DW'(17 + k);
         n_cmp++; if (fft_x_out !== exp_x) begin n_bad++; $display("FAIL bp_frame2 k=%0d got %0d want %0d", k, fft_x_out, exp_x); end
      end
      step();
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after got %b want 1", s_ready); end
      // Frame 3 (bank 0) must hold 33..48, untouched by the refused offers.
      fft_done = 1'b1; step(); fft_done = 1'b0; step();
      step();
      for (int k = 0; k < N; k++) begin
         step();
         exp_x = DW'(33 + k);
         n_cmp++; if (fft_x_out !== exp_x) begin n_bad++; $display("FAIL bp_frame3 k=%0d got %0d want %0d", k, fft_x_out, exp_x); end
      end
      $display("test_backpressure done");
   endtask

   // Bank 1 completes on the same edge bank 0 leaves S_STREAM.
   task automatic test_same_edge();
      logic signed [DW-1:0] exp_x;
      do_reset();
      for (int i = 0; i < N; i++) begin
         s_valid = 1'b1; s_data = DW'(i + 1); step();
      end
      s_valid = 1'b0;
      step();
      step();
      for (int i = 0; i < N; i++) begin
         s_valid = 1'b1; s_data = DW'(17 + i); step();
      end
      s_valid = 1'b0;
      n_cmp++; if (s_ready !== 1'b1 || busy !== 1'b1 || fft_en !== 1'b1) begin
         n_bad++; $display("FAIL same_edge_flags got ready=%b busy=%b en=%b want 1 1 1", s_ready, busy, fft_en); end
      fft_done = 1'b1; step(); fft_done = 1'b0; step();
      n_cmp++; if (busy !== 1'b0 || frame_cnt !== 8'd1) begin
         n_bad++; $display("FAIL same_edge_fill got busy=%b frame_cnt=%0d want 0 1", busy, frame_cnt); end
      step();
      n_cmp++; if (busy !== 1'b1 || fft_en !== 1'b1) begin
         n_bad++; $display("FAIL same_edge_arm got busy=%b en=%b want 1 1", busy, fft_en); end
      for (int k = 0; k < N; k++) begin
         step();
         exp_x = DW'(17 + k);
         n_cmp++; if (fft_x_out !== exp_x) begin n_bad++; $display("FAIL same_edge_x k=%0d got %0d want %0d", k, fft_x_out, exp_x); end
      end
      step();
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL same_edge_ready_end got %b want 1", s_ready); end
      $display("test_same_edge done");
   endtask

   // Asynchronous reset in the middle of streaming, then a fresh frame.
   task automatic test_reset_mid_stream();
      logic signed [DW-1:0] exp_x;
      do_reset();
      run_frame(1);
      n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL mid_pre_cnt got %0d want 1", frame_cnt); end
      for (int i = 0; i < N; i++) begin
         s_valid = 1'b1; s_data = DW'(50 + i); step();
      end
      s_valid = 1'b0;
      step();
      repeat (8) step();
      n_cmp++; if (fft_x_out !== 16'sd57) begin n_bad++; $display("FAIL mid_k7_x got %0d want 57", fft_x_out); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (fft_en !== 1'b0 || fft_mode !== 2'b00 || busy !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst_ctrl got en=%b mode=%b busy=%b want 0 00 0", fft_en, fft_mode, busy); end
      n_cmp++; if (fft_x_out !== 16'sd0 || frame_cnt !== 8'd0 || s_ready !== 1'b1) begin
         n_bad++; $display("FAIL mid_rst_regs got x=%0d frame_cnt=%0d ready=%b want 0 0 1", fft_x_out, frame_cnt, s_ready); end
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         s_valid = 1'b1; s_data = DW'(100 + i); step();
      end
      s_valid = 1'b0;
      step();
      for (int k = 0; k < N; k++) begin
         step();
         exp_x = DW'(100 + k);
         n_cmp++; if (fft_x_out !== exp_x) begin n_bad++; $display("FAIL mid_after_x k=%0d got %0d want %0d", k, fft_x_out, exp_x); end
      end
      $display("test_reset_mid_stream done");
   endtask

   task automatic test_frame_wrap();
      do_reset();
      for (int f = 0; f < 255; f++) run_frame(f);
      n_cmp++; if (frame_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_255 got %0d want 255", frame_cnt); end
      run_frame(7);
      n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_0 got %0d want 0", frame_cnt); end
      $display("test_frame_wrap done");
   endtask

   initial begin
      test_reset();
      test_stream();
      test_release();
      test_backpressure();
      test_same_edge();
      test_reset_mid_stream();
      test_frame_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
